rmt_stage_pipe: RTL and testbench
=================================

Name: rmt_stage_pipe

Overview:
- Next-generation RMT match-action stage, fully parametrised in container count, container width, key width and table depth.
- Stage 1 extracts a key from configurable PHV containers. Stage 2 does a ternary match over DEPTH entries. Stage 3 applies one ALU action to a single container.
- New over the previous stage: valid/ready backpressure end to end, a built-in control channel with quiesce, and hit/miss statistics.
- Sits between the parser (or the previous stage) and the next stage or deparser.

Parameters:
- STAGE_ID, 0: stage index; cfg writes are accepted only when cfg_stage equals this value.
- NUM_CONT, 8: PHV containers.
- CONT_W, 32: bits per container. PHV_LEN = NUM_CONT*CONT_W; container i occupies bits [i*CONT_W +: CONT_W].
- KEY_NUM, 2: containers concatenated into the key. KEY_LEN = KEY_NUM*CONT_W; key slot 0 occupies the LSBs.
- DEPTH, 16: match entries. AW = clog2(DEPTH), IW = clog2(NUM_CONT).

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- phv_in  in  PHV_LEN  input PHV
- phv_in_valid  in  1  input valid
- phv_in_ready  out  1  input ready
- phv_out  out  PHV_LEN  output PHV
- phv_out_valid  out  1  output valid
- phv_out_ready  in  1  downstream ready
- hit_out  out  1  match flag, qualified by phv_out_valid
- hit_idx_out  out  AW  index of the matching entry
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted this cycle
- cfg_stage  in  3  target stage
- cfg_target  in  2  0=key select, 1=entry key (sets entry valid), 2=entry mask, 3=action
- cfg_addr  in  AW  entry index
- cfg_data  in  max(KEY_LEN, 2+IW+CONT_W)  write data, LSB-aligned
- stat_hit_cnt  out  32  count of hit PHVs
- stat_miss_cnt  out  32  count of miss PHVs

Behaviour:
- Reset (aresetn=0 at a clock edge) clears the following:
  - all stage valids, and all entry valid bits;
  - key select register to container k for key slot k;
  - all masks and actions to 0 (action 0 = NOP);
  - both counters.
- Outputs during and right after reset: phv_out_valid=0, hit_out=0, hit_idx_out=0, phv_out=0, cfg_ready=0, stat counters 0, phv_in_ready=1 on the first cycle after reset.
- Reset mid-operation discards every in-flight PHV.
- Pipeline: registers S1 (phv, key), S2 (phv, hit, idx), S3 (output).
  - Per register: ready_k = !valid_k || ready_(k+1), with ready_4 = phv_out_ready.
  - phv_in_ready = ready_1 && !cfg_valid.
  - Latency is 3 cycles with no backpressure; throughput is 1 PHV/cycle. A full pipe holds 3 PHVs; no PHV is dropped or duplicated.
  - phv_out is stable while phv_out_valid && !phv_out_ready.
- Key extraction: key select register holds KEY_NUM fields of IW bits; key slot k = container sel[k]. A select value >= NUM_CONT yields a zero slot.
- Match: entry e hits when valid[e] && ((key ^ entry_key[e]) & entry_mask[e]) == 0, where mask bit 1 = care. The lowest index wins. No hit gives hit=0 and idx=0.
- Action word: op[1:0] at the MSB end, then dst[IW-1:0], then imm[CONT_W-1:0].
  - Ops: 0 NOP, 1 SET (c[dst]=imm), 2 ADD, 3 SUB. ADD and SUB are mod 2^CONT_W with wrap-around.
  - dst >= NUM_CONT acts as a NOP.
  - A miss forwards the PHV unchanged.
- Control channel:
  - While cfg_valid=1 no new PHV is accepted; the pipeline drains.
  - cfg_ready pulses for one cycle when cfg_valid && S1, S2 and S3 are all empty. The write commits on that edge.
  - A request with cfg_stage != STAGE_ID is also acknowledged under the same rule, but writes nothing.
  - Target 0 uses cfg_data[KEY_NUM*IW-1:0]; cfg_addr is ignored. Target 1 writes the key and sets valid. Target 2 writes the mask. Target 3 writes the action.
  - Each write is visible to the first PHV accepted after it.
  - A writer that holds cfg_valid indefinitely blocks traffic indefinitely; this is intended.
- Statistics: incremented when a PHV leaves S3 (phv_out_valid && phv_out_ready), by hit_out. They wrap at 2^32.

Decomposition:
- Package rmt_stage_pkg holds:
  - op codes (NOP, SET, ADD, SUB);
  - cfg_target codes;
  - the action-word field offsets;
  - a clog2 function.
- One sub-module, rmt_tcam_match: the combinational DEPTH-entry ternary compare plus priority encoder, outputting hit and idx, and owning the key/mask/valid arrays.

Test Plan:
- Directed scenarios below use default parameters.
- Reset then steady flow: no cfg; 10 back-to-back PHVs with phv_out_ready=1 -> each emerges unchanged 3 cycles later with hit_out=0; stat_miss_cnt=10.
- Exact hit SET:
  - Config: select {c1,c0}; entry 3 key 0x00000002_00000001, mask all ones; action SET c5=0xDEADBEEF.
  - PHV with c0=1, c1=2 -> c5=0xDEADBEEF, hit_idx_out=3.
  - PHV with c0=1, c1=3 -> miss, PHV unchanged.
- Ternary priority and wrap: entry 0 mask=0 (match-all) ADD c2+=1; entry 1 exact. PHV with c2=0xFFFFFFFF -> c2=0, hit_idx_out=0 (entry 0 wins over a matching entry 1).
- Backpressure: hold phv_out_ready=0 for 5 cycles while streaming -> phv_in_ready falls after 3 accepted PHVs; phv_out is held stable; release -> all PHVs emerge in order with none lost.
- Quiesce: assert cfg_valid while 3 PHVs are in flight -> phv_in_ready=0 immediately; cfg_ready pulses only after the third PHV leaves; the next PHV sees the new action.
- Foreign stage: cfg_stage=5 with STAGE_ID=0 -> cfg_ready pulses; table unchanged (a PHV still misses); a reset asserted mid-stream clears the pipe and both counters.

Source files
------------

// File: rtl/rmt_stage_pkg.sv
// Shared codes, action-word layout and helpers
// for the RMT match-action stage.
package rmt_stage_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_SET = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    TGT_SEL  = 2'd0,
    TGT_KEY  = 2'd1,
    TGT_MASK = 2'd2,
    TGT_ACT  = 2'd3
  } tgt_e;

  // Action word, LSB first: imm, dst, op.
  localparam int IMM_LSB = 0;

  function automatic int dst_lsb(input int cont_w);
    return cont_w;
  endfunction

  function automatic int op_lsb(input int cont_w, input int iw);
    return cont_w + iw;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rmt_tcam_match.sv
// Ternary match table: key/mask/valid storage
// plus lowest-index-wins priority encoder.
module rmt_tcam_match
  import rmt_stage_pkg::*;
#(
  parameter int KEY_LEN = 64,
  parameter int DEPTH   = 16,
  parameter int AW      = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_key,
  input  logic               wr_mask,
  input  logic [AW-1:0]      wr_addr,
  input  logic [KEY_LEN-1:0] wr_data,
  input  logic [KEY_LEN-1:0] key,
  output logic               hit,
  output logic [AW-1:0]      idx
);

  logic [KEY_LEN-1:0] ent_key  [DEPTH];
  logic [KEY_LEN-1:0] ent_mask [DEPTH];
  logic [DEPTH-1:0]   ent_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_key[e]  <= '0;
        ent_mask[e] <= '0;
      end
    end else begin
      if (wr_key) begin
        ent_key[wr_addr] <= wr_data;
        ent_vld[wr_addr] <= 1'b1;
      end
      if (wr_mask) begin
        ent_mask[wr_addr] <= wr_data;
      end
    end
  end

  // Scan high to low so the lowest matching index is left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (ent_vld[e] &&
          ((key ^ ent_key[e]) & ent_mask[e]) == '0) begin
        hit = 1'b1;
        idx = AW'(e);
      end
    end
  end

endmodule

// File: rtl/rmt_stage_pipe.sv
// RMT match-action stage: key extract, ternary match,
// single-container ALU action, with backpressure and quiesce.
module rmt_stage_pipe
  import rmt_stage_pkg::*;
#(
  parameter int STAGE_ID = 0,
  parameter int NUM_CONT = 8,
  parameter int CONT_W   = 32,
  parameter int KEY_NUM  = 2,
  parameter int DEPTH    = 16,
  parameter int PHV_LEN  = NUM_CONT * CONT_W,
  parameter int KEY_LEN  = KEY_NUM * CONT_W,
  parameter int AW       = clog2(DEPTH),
  parameter int IW       = clog2(NUM_CONT),
  parameter int ACT_W    = 2 + IW + CONT_W,
  parameter int CFG_W    = (KEY_LEN > ACT_W) ? KEY_LEN : ACT_W
) (
  input  logic               axis_clk,
  input  logic               aresetn,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_in_valid,
  output logic               phv_in_ready,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_out_valid,
  input  logic               phv_out_ready,
  output logic               hit_out,
  output logic [AW-1:0]      hit_idx_out,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_stage,
  input  logic [1:0]         cfg_target,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  output logic [31:0]        stat_hit_cnt,
  output logic [31:0]        stat_miss_cnt
);

  localparam int SEL_W   = KEY_NUM * IW;
  localparam int DST_LSB = dst_lsb(CONT_W);
  localparam int OP_LSB  = op_lsb(CONT_W, IW);

  logic [SEL_W-1:0]   sel;
  logic [ACT_W-1:0]   act [DEPTH];
  logic               v1, v2, v3;
  logic               rdy1, rdy2, rdy3;
  logic               take;
  logic [PHV_LEN-1:0] phv1, phv2;
  logic [KEY_LEN-1:0] key0, key1;
  logic               hit2, tcam_hit;
  logic [AW-1:0]      idx2, tcam_idx;
  logic [ACT_W-1:0]   act_w;
  op_e                op;
  logic [IW-1:0]      dst;
  logic [CONT_W-1:0]  imm, cur;
  logic [PHV_LEN-1:0] alu_phv;
  tgt_e               tgt;
  logic               cfg_mine;
  logic               wr_key, wr_mask;

  assign rdy3 = !v3 || phv_out_ready;
  assign rdy2 = !v2 || rdy3;
  assign rdy1 = !v1 || rdy2;

  assign phv_in_ready  = rdy1 && !cfg_valid;
  assign take          = phv_in_valid && phv_in_ready;
  assign phv_out_valid = v3;

  // Writes only land on an empty pipe, so no PHV sees a half-updated table.
  assign cfg_ready = aresetn && cfg_valid && !v1 && !v2 && !v3;
  assign cfg_mine  = cfg_ready && (cfg_stage == 3'(STAGE_ID));
  assign tgt       = tgt_e'(cfg_target);
  assign wr_key    = cfg_mine && (tgt == TGT_KEY);
  assign wr_mask   = cfg_mine && (tgt == TGT_MASK);

  always_comb begin
    key0 = '0;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (int'(sel[k*IW +: IW]) < NUM_CONT) begin
        key0[k*CONT_W +: CONT_W] =
          phv_in[int'(sel[k*IW +: IW])*CONT_W +: CONT_W];
      end
    end
  end

  rmt_tcam_match #(
    .KEY_LEN (KEY_LEN),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_tcam (
    .clk     (axis_clk),
    .rst_n   (aresetn),
    .wr_key  (wr_key),
    .wr_mask (wr_mask),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data[KEY_LEN-1:0]),
    .key     (key1),
    .hit     (tcam_hit),
    .idx     (tcam_idx)
  );

  assign act_w = act[idx2];
  assign op    = op_e'(act_w[OP_LSB +: 2]);
  assign dst   = act_w[DST_LSB +: IW];
  assign imm   = act_w[IMM_LSB +: CONT_W];

  always_comb begin
    alu_phv = phv2;
    cur     = '0;
    if (hit2 && int'(dst) < NUM_CONT) begin
      cur = phv2[int'(dst)*CONT_W +: CONT_W];
      unique case (op)
        OP_NOP: ;
        OP_SET: alu_phv[int'(dst)*CONT_W +: CONT_W] = imm;
        OP_ADD: alu_phv[int'(dst)*CONT_W +: CONT_W] = cur + imm;
        OP_SUB: alu_phv[int'(dst)*CONT_W +: CONT_W] = cur - imm;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      phv1        <= '0;
      key1        <= '0;
      phv2        <= '0;
      hit2        <= 1'b0;
      idx2        <= '0;
      phv_out     <= '0;
      hit_out     <= 1'b0;
      hit_idx_out <= '0;
    end else begin
      if (rdy1) begin
        v1 <= take;
        if (take) begin
          phv1 <= phv_in;
          key1 <= key0;
        end
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          phv2 <= phv1;
          hit2 <= tcam_hit;
          idx2 <= tcam_idx;
        end
      end
      if (rdy3) begin
        v3 <= v2;
        if (v2) begin
          phv_out     <= alu_phv;
          hit_out     <= hit2;
          hit_idx_out <= idx2;
        end
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      for (int k = 0; k < KEY_NUM; k++) begin
        sel[k*IW +: IW] <= IW'(k);
      end
      for (int e = 0; e < DEPTH; e++) begin
        act[e] <= '0;
      end
    end else if (cfg_mine) begin
      unique case (1'b1)
        tgt == TGT_SEL: sel <= cfg_data[SEL_W-1:0];
        tgt == TGT_ACT: act[cfg_addr] <= cfg_data[ACT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (v3 && phv_out_ready) begin
      if (hit_out) stat_hit_cnt <= stat_hit_cnt + 32'd1;
      else stat_miss_cnt <= stat_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rmt_stage_pipe.sv
// Directed bench for rmt_stage_pipe with an in-order
// expected-output queue checked at the falling edge.
module tb_rmt_stage_pipe;

  logic         axis_clk;
  logic         aresetn;
  logic [255:0] phv_in;
  logic         phv_in_valid;
  logic         phv_in_ready;
  logic [255:0] phv_out;
  logic         phv_out_valid;
  logic         phv_out_ready;
  logic         hit_out;
  logic [3:0]   hit_idx_out;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [2:0]   cfg_stage;
  logic [1:0]   cfg_target;
  logic [3:0]   cfg_addr;
  logic [63:0]  cfg_data;
  logic [31:0]  stat_hit_cnt;
  logic [31:0]  stat_miss_cnt;

  rmt_stage_pipe dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .phv_in        (phv_in),
    .phv_in_valid  (phv_in_valid),
    .phv_in_ready  (phv_in_ready),
    .phv_out       (phv_out),
    .phv_out_valid (phv_out_valid),
    .phv_out_ready (phv_out_ready),
    .hit_out       (hit_out),
    .hit_idx_out   (hit_idx_out),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_stage     (cfg_stage),
    .cfg_target    (cfg_target),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .stat_hit_cnt  (stat_hit_cnt),
    .stat_miss_cnt (stat_miss_cnt)
  );

  typedef struct {
    logic [255:0] phv;
    logic         hit;
    logic [3:0]   idx;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] setc(input logic [255:0] p,
                                        input int i,
                                        input logic [31:0] v);
    logic [255:0] r;
    r = p;
    r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send(input logic [255:0] p,
                      input logic [255:0] ep,
                      input logic eh,
                      input logic [3:0] ei,
                      input bit lat);
    int n;
    bit acc;
    phv_in = p;
    phv_in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge axis_clk);
      acc = phv_in_ready;
      tick();
      n++;
    end
    phv_in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
    else expq.push_back('{phv: ep, hit: eh, idx: ei,
                          cyc: cyc, lat: lat});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic cfg_write(input logic [2:0] st,
                           input logic [1:0] tg,
                           input logic [3:0] ad,
                           input logic [63:0] d);
    int n;
    cfg_stage = st;
    cfg_target = tg;
    cfg_addr = ad;
    cfg_data = d;
    cfg_valid = 1'b1;
    n = 0;
    #1;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cfg_ready) chk("cfg_timeout", 0, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Output monitor: a transfer completes at the next rising edge.
  always @(negedge axis_clk) begin
    if (aresetn && phv_out_valid && phv_out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_out", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("out_phv", phv_out, e.phv);
        chk("out_hit", hit_out, e.hit);
        chk("out_idx", hit_idx_out, e.idx);
        if (e.lat) chk("latency", cyc + 1 - e.cyc, 3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [255:0] p, pa, ea, pb, pc, ec, pe, ee, pf, pg;
  logic [255:0] pd [6];
  logic [255:0] ed [6];
  logic [255:0] pq [5];
  logic [255:0] eq [5];
  int           nw;

  initial begin
    aresetn = 1'b0;
    phv_in = '0;
    phv_in_valid = 1'b0;
    phv_out_ready = 1'b1;
    cfg_valid = 1'b0;
    cfg_stage = '0;
    cfg_target = '0;
    cfg_addr = '0;
    cfg_data = '0;
    repeat (3) tick();
    aresetn = 1'b1;
    #1;
    chk("rst_out_valid", phv_out_valid, 0);
    chk("rst_hit", hit_out, 0);
    chk("rst_idx", hit_idx_out, 0);
    chk("rst_phv", phv_out, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_hit_cnt", stat_hit_cnt, 0);
    chk("rst_miss_cnt", stat_miss_cnt, 0);
    chk("rst_in_ready", phv_in_ready, 1);

    // Steady flow, empty table: all miss, 3-cycle latency.
    for (int i = 0; i < 10; i++) begin
      p = {8{32'h01010101 * 32'(i + 1)}};
      send(p, p, 1'b0, 4'd0, 1'b1);
    end
    drain();
    chk("flow_miss_cnt", stat_miss_cnt, 10);
    chk("flow_hit_cnt", stat_hit_cnt, 0);

    // Exact hit SET on entry 3.
    cfg_write(3'd0, 2'd0, 4'd0, 64'd8);
    cfg_write(3'd0, 2'd1, 4'd3, 64'h00000002_00000001);
    cfg_write(3'd0, 2'd2, 4'd3, 64'hFFFFFFFF_FFFFFFFF);
    cfg_write(3'd0, 2'd3, 4'd3,
              64'({2'b01, 3'd5, 32'hDEADBEEF}));
    pa = {32'h77, 32'h66, 32'h55555555, 32'h44,
          32'h33, 32'h22, 32'h2, 32'h1};
    ea = {32'h77, 32'h66, 32'hDEADBEEF, 32'h44,
          32'h33, 32'h22, 32'h2, 32'h1};
    pb = {32'h77, 32'h66, 32'h55555555, 32'h44,
          32'h33, 32'h22, 32'h3, 32'h1};
    send(pa, ea, 1'b1, 4'd3, 1'b0);
    send(pb, pb, 1'b0, 4'd0, 1'b0);
    drain();

    // Match-all entry 0 beats exact entry 1; ADD wraps.
    cfg_write(3'd0, 2'd1, 4'd0, 64'd0);
    cfg_write(3'd0, 2'd2, 4'd0, 64'd0);
    cfg_write(3'd0, 2'd3, 4'd0, 64'({2'b10, 3'd2, 32'd1}));
    cfg_write(3'd0, 2'd1, 4'd1, 64'h00000002_00000001);
    cfg_write(3'd0, 2'd2, 4'd1, 64'hFFFFFFFF_FFFFFFFF);
    cfg_write(3'd0, 2'd3, 4'd1,
              64'({2'b01, 3'd7, 32'h11111111}));
    pc = {32'h77, 32'h66, 32'h55, 32'h44,
          32'h33, 32'hFFFFFFFF, 32'h2, 32'h1};
    ec = {32'h77, 32'h66, 32'h55, 32'h44,
          32'h33, 32'h0, 32'h2, 32'h1};
    send(pc, ec, 1'b1, 4'd0, 1'b0);
    drain();
    chk("t3_hit_cnt", stat_hit_cnt, 2);
    chk("t3_miss_cnt", stat_miss_cnt, 11);

    // Backpressure: 5 stalled edges, 3 PHVs fill the pipe.
    for (int i = 1; i <= 5; i++) begin
      pd[i] = {8{32'hA0A0A000 + 32'(i)}};
      ed[i] = setc(pd[i], 2, 32'hA0A0A001 + 32'(i));
    end
    phv_out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(pd[i], ed[i], 1'b1, 4'd0, 1'b0);
    phv_in = pd[4];
    phv_in_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("bp_in_ready", phv_in_ready, 0);
      chk("bp_hold_phv", phv_out, ed[1]);
      chk("bp_hold_valid", phv_out_valid, 1);
      tick();
    end
    phv_out_ready = 1'b1;
    send(pd[4], ed[4], 1'b1, 4'd0, 1'b0);
    send(pd[5], ed[5], 1'b1, 4'd0, 1'b0);
    drain();
    chk("bp_hit_cnt", stat_hit_cnt, 7);

    // Quiesce with 3 PHVs in flight, then SUB takes effect.
    for (int i = 1; i <= 3; i++) begin
      pq[i] = {8{32'hB0B0B000 + 32'(i)}};
      eq[i] = setc(pq[i], 2, 32'hB0B0B001 + 32'(i));
    end
    pq[4] = setc({8{32'hB0B0B004}}, 2, 32'h2);
    eq[4] = setc({8{32'hB0B0B004}}, 2, 32'hFFFFFFFF);
    for (int i = 1; i <= 3; i++) send(pq[i], eq[i], 1'b1, 4'd0, 1'b0);
    phv_in = pq[4];
    phv_in_valid = 1'b1;
    cfg_stage = 3'd0;
    cfg_target = 2'd3;
    cfg_addr = 4'd0;
    cfg_data = 64'({2'b11, 3'd2, 32'd3});
    cfg_valid = 1'b1;
    #1;
    chk("q_in_ready", phv_in_ready, 0);
    chk("q_cfg_early", cfg_ready, 0);
    nw = 0;
    while (!cfg_ready && nw < 50) begin
      tick();
      nw++;
    end
    chk("q_wait_cycles", nw, 3);
    chk("q_inflight", expq.size(), 0);
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("q_cfg_pulse", cfg_ready, 0);
    send(pq[4], eq[4], 1'b1, 4'd0, 1'b0);
    drain();
    chk("q_hit_cnt", stat_hit_cnt, 11);

    // Non-default key select hits entry 1.
    cfg_write(3'd0, 2'd2, 4'd0, 64'hFFFFFFFF_FFFFFFFF);
    cfg_write(3'd0, 2'd0, 4'd0, 64'd28);
    pe = {32'h77, 32'h66, 32'h55, 32'h1,
          32'h2, 32'h22, 32'h9, 32'h9};
    ee = {32'h11111111, 32'h66, 32'h55, 32'h1,
          32'h2, 32'h22, 32'h9, 32'h9};
    send(pe, ee, 1'b1, 4'd1, 1'b0);
    drain();

    // Foreign stage write is acked but changes nothing.
    cfg_write(3'd0, 2'd0, 4'd0, 64'd8);
    cfg_write(3'd5, 2'd1, 4'd4, 64'h00000007_00000007);
    pf = {8{32'h7}};
    send(pf, pf, 1'b0, 4'd0, 1'b0);
    drain();
    chk("fs_hit_cnt", stat_hit_cnt, 12);
    chk("fs_miss_cnt", stat_miss_cnt, 12);

    // Reset mid-stream discards in-flight PHVs and tables.
    phv_in = {8{32'hC0C0C001}};
    phv_in_valid = 1'b1;
    tick();
    phv_in = {8{32'hC0C0C002}};
    tick();
    phv_in_valid = 1'b0;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    #1;
    chk("rst2_hit_cnt", stat_hit_cnt, 0);
    chk("rst2_miss_cnt", stat_miss_cnt, 0);
    chk("rst2_phv", phv_out, 0);
    chk("rst2_valid", phv_out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst2_flush", phv_out_valid, 0);
    end
    pg = {32'h0, 32'h0, 32'h0, 32'h0,
          32'h0, 32'h0, 32'h2, 32'h1};
    send(pg, pg, 1'b0, 4'd0, 1'b0);
    drain();
    chk("rst2_after_miss", stat_miss_cnt, 1);
    chk("rst2_after_hit", stat_hit_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
